mult_share_arb: RTL



---
 rtl/mult_share_arb_if.sv | 27 ++
 rtl/mult_share_arb.sv | 93 +++++++++
 2 files changed

// File: rtl/mult_share_arb_if.sv
// rtl/mult_share_arb_if.sv - request, shared-multiplier and response signals of mult_share_arb
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*15-1:0] req_a;
  logic [NREQ*18-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [14:0]        mult_dataa;
  logic [17:0]        mult_datab;
  logic [17:0]        mult_product;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [17:0]        rsp_product;

  modport slave (
    input  req_valid, req_a, req_b, mult_product, rsp_ready,
    output req_ready, mult_dataa, mult_datab, rsp_valid, rsp_id, rsp_product
  );

  modport master (
    output req_valid, req_a, req_b, mult_product, rsp_ready,
    input  req_ready, mult_dataa, mult_datab, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin sharing of one 15x18 multiplier; MULT_ARB_FIXED_PRIO_EN selects fixed priority
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_share_arb_if.slave bus
);

  logic            adv;
  logic            found;
  logic [IDW-1:0]  gid;
  logic [14:0]     sel_a;
  logic [17:0]     sel_b;
  logic [NREQ-1:0] ready_c;
  int              idx;

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [14:0]     dataa_q;
  logic [17:0]     datab_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [17:0]     rsp_product_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr;
`endif

  // The whole pipeline moves as one; a stalled output freezes S1 so the product stays valid.
  assign adv = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    found   = 1'b0;
    gid     = '0;
    sel_a   = '0;
    sel_b   = '0;
    ready_c = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr) + k) % NREQ;
`endif
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gid   = IDW'(idx);
        sel_a = bus.req_a[idx*15 +: 15];
        sel_b = bus.req_b[idx*18 +: 18];
      end
    end
    if (adv && found) begin
      ready_c[gid] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_id         <= '0;
      dataa_q       <= '0;
      datab_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else if (adv) begin
      s1_valid <= found;
      if (found) begin
        s1_id   <= gid;
        dataa_q <= sel_a;
        datab_q <= sel_b;
`ifndef MULT_ARB_FIXED_PRIO_EN
        ptr     <= IDW'((int'(gid) + 1) % NREQ);
`endif
      end
      rsp_valid_q   <= s1_valid;
      rsp_id_q      <= s1_id;
      rsp_product_q <= bus.mult_product;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.mult_dataa  = dataa_q;
  assign bus.mult_datab  = datab_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;

endmodule
